// File: rtl/pingpong_ring_pkg.sv
// Shared types and helpers for the multi-bank ping-pong frame buffer.
package pingpong_ring_pkg;

    // Reader behaviour once the last word of a frame has been issued.
    typedef enum logic [0:0] {
        MODE_SINGLE   = 1'b0,
        MODE_CIRCULAR = 1'b1
    } read_mode_e;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pingpong_ring_buffer_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module sdp_ram #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int WORDS     = 32
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 re_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [WIDTH-1:0]     rdata_o
);

    logic [WIDTH-1:0] mem_q [WORDS];
    logic [WIDTH-1:0] rdata_q;

    // Storage array written on the write port; kept reset-free so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read: data for an address issued in cycle N is visible in cycle N+1.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pingpong_ring_buffer.sv
// Multi-bank frame buffer: the writer fills banks in ring order, the reader drains
// committed frames through a RAM with 1-cycle latency and a 2-entry output FIFO.
module pingpong_ring_buffer
    import pingpong_ring_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int NUM_BANKS  = 2,
    parameter int CIRCULAR   = 0,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int BANK_WIDTH = clog2_min1(NUM_BANKS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [WIDTH-1:0]      write_data_i,
    input  logic                  write_valid_i,
    output logic                  write_ready_o,
    input  logic                  flush_i,
    output logic [WIDTH-1:0]      read_data_o,
    output logic                  read_valid_o,
    input  logic                  read_ready_i,
    output logic                  read_last_o,
    output logic                  frame_ready_o,
    output logic                  overflow_o,
    output logic [BANK_WIDTH:0]   frames_full_o,
    output logic [ADDR_WIDTH:0]   write_count_o,
    output logic [ADDR_WIDTH:0]   read_count_o
);

    localparam read_mode_e MODE = (CIRCULAR != 0) ? MODE_CIRCULAR : MODE_SINGLE;
    // Banks are addressed as {bank, word}, so each bank occupies a power-of-two slot.
    localparam int RAM_WORDS = NUM_BANKS * (1 << ADDR_WIDTH);

    logic [BANK_WIDTH-1:0] wbank_q, wbank_d, rbank_q, rbank_d;
    logic [ADDR_WIDTH:0]   write_count_q, write_count_d;
    logic [ADDR_WIDTH:0]   read_count_q, read_count_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [BANK_WIDTH:0]   occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic                  frame_ready_q, frame_ready_d;
    logic                  overflow_q, overflow_d;
    logic [WIDTH-1:0]      fifo_data_q [0:1];
    logic [WIDTH-1:0]      fifo_data_d [0:1];
    logic                  fifo_wptr_q, fifo_wptr_d, fifo_rptr_q, fifo_rptr_d;
    logic [1:0]            fifo_count_q, fifo_count_d;

    logic                  write_accept, commit, ram_we;
    logic                  issue, last_word, release_bank;
    logic                  out_valid, pop, fifo_pop, fifo_push;
    logic [WIDTH-1:0]      ram_rdata;

    function automatic logic [BANK_WIDTH-1:0] bank_inc(input logic [BANK_WIDTH-1:0] b);
        return (b == BANK_WIDTH'(NUM_BANKS - 1)) ? '0 : b + BANK_WIDTH'(1);
    endfunction

    assign write_ready_o = (occ_q < (BANK_WIDTH+1)'(NUM_BANKS));

    // Writer: accept words into the fill bank, commit on the last word, flush wins over commit.
    always_comb begin
        write_count_d = write_count_q;
        wbank_d       = wbank_q;
        write_accept  = write_valid_i && write_ready_o;
        commit        = write_accept && !flush_i &&
                        (write_count_q == (ADDR_WIDTH+1)'(DEPTH - 1));
        ram_we        = write_accept && !flush_i && !rst_i;
        overflow_d    = write_valid_i && !write_ready_o;
        frame_ready_d = commit;
        if (flush_i) begin
            write_count_d = '0;
        end else if (write_accept) begin
            if (commit) begin
                write_count_d = '0;
                wbank_d       = bank_inc(wbank_q);
            end else begin
                write_count_d = write_count_q + (ADDR_WIDTH+1)'(1);
            end
        end
    end

    // Reader: issue RAM reads while the FIFO plus in-flight word has room, release or wrap at the last word.
    always_comb begin
        raddr_d      = raddr_q;
        rbank_d      = rbank_q;
        occ_d        = occ_q;
        issue        = (occ_q != '0) && ((fifo_count_q + {1'b0, inflight_q}) < 2'd2);
        last_word    = (raddr_q == ADDR_WIDTH'(DEPTH - 1));
        release_bank = issue && last_word &&
                       ((MODE == MODE_SINGLE) || (occ_q > (BANK_WIDTH+1)'(1)));
        inflight_d   = issue;
        if (issue) begin
            if (last_word) begin
                raddr_d = '0;
                if (release_bank) begin
                    rbank_d = bank_inc(rbank_q);
                end
            end else begin
                raddr_d = raddr_q + ADDR_WIDTH'(1);
            end
        end
        if (commit && !release_bank) begin
            occ_d = occ_q + (BANK_WIDTH+1)'(1);
        end else if (release_bank && !commit) begin
            occ_d = occ_q - (BANK_WIDTH+1)'(1);
        end
    end

    // Output FIFO: the RAM word bypasses straight to the output when the FIFO is empty and the consumer takes it.
    always_comb begin
        fifo_data_d  = fifo_data_q;
        fifo_wptr_d  = fifo_wptr_q;
        fifo_rptr_d  = fifo_rptr_q;
        fifo_count_d = fifo_count_q;
        read_count_d = read_count_q;
        out_valid    = (fifo_count_q != 2'd0) || inflight_q;
        pop          = out_valid && read_ready_i;
        fifo_pop     = pop && (fifo_count_q != 2'd0);
        fifo_push    = inflight_q && !((fifo_count_q == 2'd0) && read_ready_i);
        if (fifo_push) begin
            fifo_data_d[fifo_wptr_q] = ram_rdata;
            fifo_wptr_d              = ~fifo_wptr_q;
        end
        if (fifo_pop) begin
            fifo_rptr_d = ~fifo_rptr_q;
        end
        if (fifo_push && !fifo_pop) begin
            fifo_count_d = fifo_count_q + 2'd1;
        end else if (fifo_pop && !fifo_push) begin
            fifo_count_d = fifo_count_q - 2'd1;
        end
        if (pop) begin
            read_count_d = (read_count_q == (ADDR_WIDTH+1)'(DEPTH - 1)) ? '0
                         : read_count_q + (ADDR_WIDTH+1)'(1);
        end
    end

    // State register with synchronous reset that drops all frames and any in-flight read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wbank_q       <= '0;
            rbank_q       <= '0;
            write_count_q <= '0;
            read_count_q  <= '0;
            raddr_q       <= '0;
            occ_q         <= '0;
            inflight_q    <= 1'b0;
            frame_ready_q <= 1'b0;
            overflow_q    <= 1'b0;
            fifo_data_q   <= '{default: '0};
            fifo_wptr_q   <= 1'b0;
            fifo_rptr_q   <= 1'b0;
            fifo_count_q  <= 2'd0;
        end else begin
            wbank_q       <= wbank_d;
            rbank_q       <= rbank_d;
            write_count_q <= write_count_d;
            read_count_q  <= read_count_d;
            raddr_q       <= raddr_d;
            occ_q         <= occ_d;
            inflight_q    <= inflight_d;
            frame_ready_q <= frame_ready_d;
            overflow_q    <= overflow_d;
            fifo_data_q   <= fifo_data_d;
            fifo_wptr_q   <= fifo_wptr_d;
            fifo_rptr_q   <= fifo_rptr_d;
            fifo_count_q  <= fifo_count_d;
        end
    end

    sdp_ram #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (BANK_WIDTH + ADDR_WIDTH),
        .WORDS     (RAM_WORDS)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i ({wbank_q, write_count_q[ADDR_WIDTH-1:0]}),
        .wdata_i (write_data_i),
        .re_i    (issue),
        .raddr_i ({rbank_q, raddr_q}),
        .rdata_o (ram_rdata)
    );

    assign read_valid_o  = out_valid;
    assign read_data_o   = !out_valid ? '0
                         : (fifo_count_q != 2'd0) ? fifo_data_q[fifo_rptr_q] : ram_rdata;
    assign read_last_o   = out_valid && (read_count_q == (ADDR_WIDTH+1)'(DEPTH - 1));
    assign frame_ready_o = frame_ready_q;
    assign overflow_o    = overflow_q;
    assign frames_full_o = occ_q;
    assign write_count_o = write_count_q;
    assign read_count_o  = read_count_q;

endmodule

// File: tb/tb_pingpong_ring_buffer.sv
// Directed bench for pingpong_ring_buffer with DEPTH=4, NUM_BANKS=3: a single-pass
// instance and a circular instance share the clock but have separate stimulus.
module tb_pingpong_ring_buffer;

    logic        clk = 1'b0;
    int          checks = 0;
    int          errors = 0;

    // Single-pass instance signals
    logic        rst = 1'b1, wvalid = 1'b0, flush = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic        wready, rvalid, rlast, fready, ovf;
    logic [31:0] rdata;
    logic [2:0]  ffull, wcount, rcount;

    // Circular instance signals
    logic        c_rst = 1'b1, c_wvalid = 1'b0, c_flush = 1'b0, c_rready = 1'b0;
    logic [31:0] c_wdata = '0;
    logic        c_wready, c_rvalid, c_rlast, c_fready, c_ovf;
    logic [31:0] c_rdata;
    logic [2:0]  c_ffull, c_wcount, c_rcount;

    typedef struct {
        bit rst; bit wv; int wd; bit fl; bit rr; bit chk;
        bit e_wr; bit e_rv; int e_rd; bit e_last; bit e_fr; bit e_ov;
        int e_ff; int e_wc; int e_rc;
    } vec_t;

    vec_t vecs[$];

    pingpong_ring_buffer #(.WIDTH(32), .DEPTH(4), .NUM_BANKS(3), .CIRCULAR(0)) dut (
        .clk_i(clk), .rst_i(rst), .write_data_i(wdata), .write_valid_i(wvalid),
        .write_ready_o(wready), .flush_i(flush), .read_data_o(rdata),
        .read_valid_o(rvalid), .read_ready_i(rready), .read_last_o(rlast),
        .frame_ready_o(fready), .overflow_o(ovf), .frames_full_o(ffull),
        .write_count_o(wcount), .read_count_o(rcount)
    );

    pingpong_ring_buffer #(.WIDTH(32), .DEPTH(4), .NUM_BANKS(3), .CIRCULAR(1)) dut_c (
        .clk_i(clk), .rst_i(c_rst), .write_data_i(c_wdata), .write_valid_i(c_wvalid),
        .write_ready_o(c_wready), .flush_i(c_flush), .read_data_o(c_rdata),
        .read_valid_o(c_rvalid), .read_ready_i(c_rready), .read_last_o(c_rlast),
        .frame_ready_o(c_fready), .overflow_o(c_ovf), .frames_full_o(c_ffull),
        .write_count_o(c_wcount), .read_count_o(c_rcount)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    task automatic step;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst    = v.rst;
        wvalid = v.wv;
        wdata  = 32'(v.wd);
        flush  = v.fl;
        rready = v.rr;
    endtask

    function automatic vec_t mk(input bit r, input bit wv, input int wd, input bit fl,
                                input bit chk, input bit wr, input bit rv, input int rd,
                                input bit last, input bit fr, input int ff, input int wc,
                                input int rc);
        vec_t v;
        v.rst = r; v.wv = wv; v.wd = wd; v.fl = fl; v.rr = 1'b1; v.chk = chk;
        v.e_wr = wr; v.e_rv = rv; v.e_rd = rd; v.e_last = last; v.e_fr = fr;
        v.e_ov = 1'b0; v.e_ff = ff; v.e_wc = wc; v.e_rc = rc;
        return v;
    endfunction

    initial begin
        int rx;
        int wi;
        bit seen_ready;
        bit prev_stall;
        logic [31:0] prev_data;
        bit rr_now;

        // Reset, single frame, partial flush, flush on the final word
        //              rst wv wd     fl chk wr rv rd     lst fr ff wc rc
        vecs.push_back(mk(1, 1, 'h55, 0, 0,  1, 0, 0,     0,  0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 'h55, 0, 1,  1, 0, 0,     0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,    0, 1,  1, 0, 0,     0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'hA0, 0, 1,  1, 0, 0,     0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'hA1, 0, 1,  1, 0, 0,     0,  0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 'hA2, 0, 1,  1, 0, 0,     0,  0, 0, 2, 0));
        vecs.push_back(mk(0, 1, 'hA3, 0, 1,  1, 0, 0,     0,  0, 0, 3, 0));
        vecs.push_back(mk(0, 0, 0,    0, 1,  1, 0, 0,     0,  1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,    0, 1,  1, 1, 'hA0,  0,  0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,    0, 1,  1, 1, 'hA1,  0,  0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0,    0, 1,  1, 1, 'hA2,  0,  0, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0,    0, 1,  1, 1, 'hA3,  1,  0, 0, 0, 3));
        vecs.push_back(mk(0, 1, 'hD0, 0, 1,  1, 0, 0,     0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'hD1, 0, 1,  1, 0, 0,     0,  0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,    1, 1,  1, 0, 0,     0,  0, 0, 2, 0));
        vecs.push_back(mk(0, 1, 'hC0, 0, 1,  1, 0, 0,     0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'hC1, 0, 1,  1, 0, 0,     0,  0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 'hC2, 0, 1,  1, 0, 0,     0,  0, 0, 2, 0));
        vecs.push_back(mk(0, 1, 'hC3, 0, 1,  1, 0, 0,     0,  0, 0, 3, 0));
        vecs.push_back(mk(0, 0, 0,    0, 1,  1, 0, 0,     0,  1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,    0, 1,  1, 1, 'hC0,  0,  0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,    0, 1,  1, 1, 'hC1,  0,  0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0,    0, 1,  1, 1, 'hC2,  0,  0, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0,    0, 1,  1, 1, 'hC3,  1,  0, 0, 0, 3));
        vecs.push_back(mk(0, 1, 'hE0, 0, 1,  1, 0, 0,     0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'hE1, 0, 1,  1, 0, 0,     0,  0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 'hE2, 0, 1,  1, 0, 0,     0,  0, 0, 2, 0));
        vecs.push_back(mk(0, 1, 'hE3, 1, 1,  1, 0, 0,     0,  0, 0, 3, 0));
        vecs.push_back(mk(0, 0, 0,    0, 1,  1, 0, 0,     0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,    0, 1,  1, 0, 0,     0,  0, 0, 0, 0));

        $display("[TB] table vectors");
        foreach (vecs[i]) begin
            step;
            if (vecs[i].chk) begin
                checkOutput($sformatf("v%0d_wready", i), {31'b0, wready}, {31'b0, vecs[i].e_wr});
                checkOutput($sformatf("v%0d_rvalid", i), {31'b0, rvalid}, {31'b0, vecs[i].e_rv});
                if (vecs[i].e_rv)
                    checkOutput($sformatf("v%0d_rdata", i), rdata, 32'(vecs[i].e_rd));
                checkOutput($sformatf("v%0d_rlast", i), {31'b0, rlast}, {31'b0, vecs[i].e_last});
                checkOutput($sformatf("v%0d_fready", i), {31'b0, fready}, {31'b0, vecs[i].e_fr});
                checkOutput($sformatf("v%0d_ovf", i), {31'b0, ovf}, {31'b0, vecs[i].e_ov});
                checkOutput($sformatf("v%0d_ffull", i), {29'b0, ffull}, 32'(vecs[i].e_ff));
                checkOutput($sformatf("v%0d_wcount", i), {29'b0, wcount}, 32'(vecs[i].e_wc));
                checkOutput($sformatf("v%0d_rcount", i), {29'b0, rcount}, 32'(vecs[i].e_rc));
            end
            applyStimulus(vecs[i]);
        end

        // Overflow: fill all three banks with the reader stalled, then attempt a 13th word
        $display("[TB] overflow");
        rready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step;
            checkOutput("ovf_ready_before", {31'b0, wready}, 32'd1);
            wvalid = 1'b1;
            wdata  = 32'h10 + 32'(i);
        end
        step;
        checkOutput("ovf_ready_low", {31'b0, wready}, 32'd0);
        checkOutput("ovf_full", {29'b0, ffull}, 32'd3);
        checkOutput("ovf_pulse_pre", {31'b0, ovf}, 32'd0);
        wdata = 32'hFF;
        step;
        checkOutput("ovf_pulse", {31'b0, ovf}, 32'd1);
        checkOutput("ovf_wcount", {29'b0, wcount}, 32'd0);
        checkOutput("ovf_full_after", {29'b0, ffull}, 32'd3);
        wvalid = 1'b0;
        step;
        checkOutput("ovf_pulse_once", {31'b0, ovf}, 32'd0);
        rready = 1'b1;
        rx = 0;
        seen_ready = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (!seen_ready && wready) begin
                seen_ready = 1'b1;
                checkOutput("ovf_ready_return_valid", {31'b0, rvalid}, 32'd1);
                checkOutput("ovf_ready_return_word", rdata, 32'h13);
            end
            if (rvalid) begin
                checkOutput("ovf_word", rdata, 32'h10 + 32'(rx));
                checkOutput("ovf_last", {31'b0, rlast}, {31'b0, (rx % 4) == 3});
                rx++;
            end
            step;
        end
        checkOutput("ovf_words", 32'(rx), 32'd12);
        checkOutput("ovf_ready_seen", {31'b0, seen_ready}, 32'd1);
        checkOutput("ovf_drained", {29'b0, ffull}, 32'd0);

        // Reset in the middle of a frame with reads pending
        $display("[TB] mid-frame reset");
        rready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wvalid = 1'b1;
            wdata  = 32'h20 + 32'(i);
            step;
        end
        wvalid = 1'b0;
        step;
        step;
        checkOutput("mrst_pre_full", {29'b0, ffull}, 32'd1);
        checkOutput("mrst_pre_valid", {31'b0, rvalid}, 32'd1);
        rst = 1'b1;
        step;
        rst = 1'b0;
        checkOutput("mrst_valid", {31'b0, rvalid}, 32'd0);
        checkOutput("mrst_full", {29'b0, ffull}, 32'd0);
        checkOutput("mrst_wcount", {29'b0, wcount}, 32'd0);
        checkOutput("mrst_wready", {31'b0, wready}, 32'd1);
        rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step;
            checkOutput("mrst_no_stale", {31'b0, rvalid}, 32'd0);
        end

        // Circular mode: A loops until B commits during the third pass
        $display("[TB] circular");
        c_rready = 1'b1;
        step;
        c_rst = 1'b0;
        for (int t = 0; t < 34; t++) begin
            int k;
            int exp_ff;
            step;
            k = t - 5;
            if (t >= 5) begin
                checkOutput("circ_valid", {31'b0, c_rvalid}, 32'd1);
                checkOutput("circ_data", c_rdata, ((k < 12) ? 32'hA0 : 32'hB0) + 32'(k % 4));
                checkOutput("circ_last", {31'b0, c_rlast}, {31'b0, (k % 4) == 3});
                checkOutput("circ_rcount", {29'b0, c_rcount}, 32'(k % 4));
            end else begin
                checkOutput("circ_idle", {31'b0, c_rvalid}, 32'd0);
            end
            checkOutput("circ_fready", {31'b0, c_fready}, {31'b0, (t == 4) || (t == 14)});
            exp_ff = (t < 4) ? 0 : (t < 14) ? 1 : (t < 16) ? 2 : 1;
            checkOutput("circ_ffull", {29'b0, c_ffull}, 32'(exp_ff));
            if (t < 4) begin
                c_wvalid = 1'b1;
                c_wdata  = 32'hA0 + 32'(t);
            end else if (t >= 10 && t < 14) begin
                c_wvalid = 1'b1;
                c_wdata  = 32'hB0 + 32'(t - 10);
            end else begin
                c_wvalid = 1'b0;
            end
        end

        // Random backpressure over five frames
        $display("[TB] backpressure");
        wi = 0;
        rx = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int cyc = 0; cyc < 600 && rx < 20; cyc++) begin
            if (prev_stall) begin
                checkOutput("bp_hold_valid", {31'b0, rvalid}, 32'd1);
                checkOutput("bp_hold_data", rdata, prev_data);
            end
            rr_now = 1'($urandom_range(0, 1));
            rready = rr_now;
            if (rvalid && rr_now) begin
                checkOutput("bp_data", rdata, 32'h100 + 32'(rx));
                checkOutput("bp_last", {31'b0, rlast}, {31'b0, (rx % 4) == 3});
                rx++;
            end
            prev_stall = rvalid && !rr_now;
            prev_data  = rdata;
            if (wi < 20 && wready) begin
                wvalid = 1'b1;
                wdata  = 32'h100 + 32'(wi);
                wi++;
            end else begin
                wvalid = 1'b0;
            end
            step;
        end
        wvalid = 1'b0;
        checkOutput("bp_words", 32'(rx), 32'd20);
        rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step;
            checkOutput("bp_no_extra", {31'b0, rvalid}, 32'd0);
        end
        checkOutput("bp_empty", {29'b0, ffull}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pingpong_ring_buffer.md
Name: pingpong_ring_buffer

Overview:
- Generalised multi-bank frame buffer. NUM_BANKS (>=2) buffers of DEPTH words are filled and drained in ring order.
- The writer fills one bank at a time. A bank becomes a "frame" when it holds DEPTH words. The reader drains committed frames in order.
- Read mode is single-pass (each frame read once, then freed) or circular (the current frame loops until a newer frame exists).
- Sits between the sample producer (mic/ADC front end) and the frame consumer (DSP/UART). Storage is inferred RAM, with no vendor primitive.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- DEPTH, 16, words per frame (>=2).
- NUM_BANKS, 2, number of frame banks (>=2).
- CIRCULAR, 0, read mode: 0 = single-pass, 1 = circular.
- ADDR_WIDTH, $clog2(DEPTH), word address width (derived).
- BANK_WIDTH, $clog2(NUM_BANKS), bank index width (derived).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- write_data_i  in  WIDTH  write word
- write_valid_i  in  1  write request
- write_ready_o  out  1  write can be accepted
- flush_i  in  1  discard the partially filled write frame
- read_data_o  out  WIDTH  read word
- read_valid_o  out  1  read_data_o valid
- read_ready_i  in  1  consumer accepts the word
- read_last_o  out  1  current word is the last word (DEPTH-1) of its pass
- frame_ready_o  out  1  one-cycle pulse: a frame was committed
- overflow_o  out  1  one-cycle pulse: a write was attempted while write_ready_o=0
- frames_full_o  out  BANK_WIDTH+1  number of committed, unreleased frames
- write_count_o  out  ADDR_WIDTH+1  words in the current write frame
- read_count_o  out  ADDR_WIDTH+1  index of the word presented at read_data_o

Behaviour:
- Reset (rst_i=1 at a posedge): all banks free; write and read bank pointers = 0; all counters = 0; all outputs = 0 except write_ready_o=1. Reset mid-frame discards all data and drops any in-flight read.
- Occupancy: occ = frames_full_o. write_ready_o = (occ < NUM_BANKS), combinational from registered state.
- Write accept:
  - A write is accepted when write_valid_i && write_ready_o.
  - The word is stored at {wbank, write_count}, and write_count increments.
  - On the accept that makes write_count == DEPTH: commit. occ increments, wbank advances modulo NUM_BANKS, write_count returns to 0, and frame_ready_o=1 on the next cycle.
- Overflow: write_valid_i && !write_ready_o. The word is dropped, overflow_o=1 on the next cycle, and no state changes.
- Flush:
  - flush_i=1 sets write_count to 0 with no commit and no pulse.
  - If flush_i coincides with an accepted write, flush wins: the word is discarded and no commit occurs, even if it was the final word.
- Read path:
  - The RAM has 1-cycle read latency.
  - A 2-entry output FIFO feeds read_data_o/read_valid_o/read_last_o. A RAM read issues when occ > 0 and (FIFO count + in-flight) < 2.
  - Sustained throughput is 1 word/cycle with read_ready_i=1.
  - Data, valid and last are held stable while read_valid_o && !read_ready_i.
- First-word latency: if the committing write is accepted in cycle T, frame_ready_o is high in T+1 and the first read issues in T+1. read_valid_o with word 0 is high in T+2.
- Single-pass mode (CIRCULAR=0): after the read of word DEPTH-1 issues, the bank is released. occ decrements, rbank advances, and the next issue starts that bank at word 0.
- Circular mode (CIRCULAR=1): at issue of word DEPTH-1:
  - if occ > 1, release the bank and advance;
  - otherwise wrap to word 0 of the same bank; no release, and read_valid_o stays high.
- Commit and release in the same cycle: occ is unchanged. write_ready_o is recomputed from the new occ.
- The reader never addresses the bank being filled, because only committed banks are read.
- read_count_o tracks the word at the output, not the issue address. It wraps to 0 after DEPTH-1.

Decomposition:
- Package pingpong_ring_pkg holds:
  - read_mode_e (MODE_SINGLE, MODE_CIRCULAR);
  - a clog2-min-1 helper function for BANK_WIDTH when NUM_BANKS=2.
- One sub-module, sdp_ram: simple dual-port memory, NUM_BANKS*DEPTH words x WIDTH, one write port, one registered read port. Address = {bank, word}.
- The output FIFO, pointers and counters stay in the top module.

Test Plan (DEPTH=4, NUM_BANKS=3 unless stated):
1. Reset → assert rst_i for 2 cycles with write_valid_i=1 → all outputs 0, write_ready_o=1 after release, no RAM write.
2. Single-pass frame:
   - Stimulus: write 0xA0..0xA3 back-to-back, read_ready_i=1.
   - frame_ready_o pulses in T+1; A0..A3 appear on consecutive cycles from T+2; read_last_o is set only with A3; frames_full_o goes 1→0.
3. Overflow:
   - Stimulus: read_ready_i=0; write 12 words, then a 13th word 0xFF.
   - write_ready_o drops after the 12th accept, overflow_o pulses once, and 0xFF never appears on reads.
   - Then raise read_ready_i: frames 1-3 are read intact in order, and write_ready_o returns to 1 after frame 1's last issue.
4. Circular mode:
   - Stimulus: CIRCULAR=1; commit A0..A3; hold read_ready_i=1 for 10 words; then commit B0..B3 during the 3rd pass.
   - Output: A0 A1 A2 A3 A0 A1 A2 A3 A0 A1, then the rest of the current A pass, then B0.. looping.
5. Flush:
   - Stimulus: write 2 words, assert flush_i, then write C0..C3.
   - write_count_o goes to 0; exactly one frame_ready_o pulse; the read returns C0..C3 only.
   - Also assert flush_i coincident with a 4th write: no commit.
6. Backpressure: random read_ready_i at 50% over 5 frames → no loss or duplication, and data stays stable while stalled.
